// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared state encoding and direction constants for the step generator
// Contents: state_e (IDLE, ACCEL, RUN, DECEL), FWD/REV direction levels.
package stepper_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCEL = 2'd1,
      RUN   = 2'd2,
      DECEL = 2'd3
   } state_e;

   localparam logic FWD = 1'b1;
   localparam logic REV = 1'b0;

endpackage

// File: rtl/stepper_step_gen_if.sv
// rtl/stepper_step_gen_if.sv - move-command handshake between command source and step generator
// Signals: cmd_valid, cmd_ready, cmd_steps[STEPS_W], cmd_dir, cmd_period[PERIOD_W].
// master = command source, slave = step generator.
interface stepper_step_gen_if #(
   parameter int STEPS_W  = 24,
   parameter int PERIOD_W = 16
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [STEPS_W-1:0]  cmd_steps;
   logic                cmd_dir;
   logic [PERIOD_W-1:0] cmd_period;

   modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, input cmd_ready);
   modport slave  (input cmd_valid, cmd_steps, cmd_dir, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_tick_div.sv
// rtl/step_tick_div.sv - free-running TICK_DIV prescaler producing a one-cycle tick strobe
// Ports: clk, rst (sync, active high), restart_i (zero the count), tick_o (high while count==TICK_DIV-1).
module step_tick_div #(
   parameter int TICK_DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      if (restart_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/stepper_step_gen.sv
// rtl/stepper_step_gen.sv - step-pulse generator executing move commands, optional trapezoidal ramp
// Optional feature macro: STEP_RAMP_EN (ACCEL/DECEL ramp); undefined = constant-period moves.
// Ports: clk, rst (sync, active high); cmd (stepper_step_gen_if.slave: valid/ready/steps/dir/period);
//   stop (abort level); rotate_pulse (toggles per step); direction (latched cmd_dir);
//   module_enable/busy (move active); done (1-cycle end pulse); position (signed step count).
module stepper_step_gen
   import stepper_pkg::*;
#(
   parameter int TICK_DIV     = 27,
   parameter int PERIOD_W     = 16,
   parameter int STEPS_W      = 24,
   parameter int POS_W        = 32,
   parameter int START_PERIOD = 20000,
   parameter int RAMP_DEC     = 200
) (
   input  logic                    clk,
   input  logic                    rst,
   stepper_step_gen_if.slave       cmd,
   input  logic                    stop,
   output logic                    rotate_pulse,
   output logic                    direction,
   output logic                    module_enable,
   output logic                    busy,
   output logic                    done,
   output logic signed [POS_W-1:0] position
);
   localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

   state_e              state_q, state_d;
   logic [STEPS_W-1:0]  rem_q, rem_d;
   logic [PERIOD_W-1:0] cur_q, cur_d;
   logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
   logic [PERIOD_W-1:0] cmd_cruise;
   logic                dir_q, dir_d;
   logic                rot_q, rot_d;
   logic                done_q, done_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                tick, accept, step_due;

`ifdef STEP_RAMP_EN
   localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
   localparam logic [PERIOD_W-1:0] DEC_P   = PERIOD_W'(RAMP_DEC);

   logic [STEPS_W-1:0]  nacc_q, nacc_d;
   logic [PERIOD_W-1:0] cruise_q, cruise_d;

   // Slow down by one ramp increment without passing START_P; a period already
   // slower than START_P (cruise above start) is left alone.
   function automatic logic [PERIOD_W-1:0] ramp_up(input logic [PERIOD_W-1:0] p);
      if (p >= START_P) return p;
      if ((START_P - p) <= DEC_P) return START_P;
      return p + DEC_P;
   endfunction
`else
   logic unused_cfg;
   assign unused_cfg = ^{START_PERIOD, RAMP_DEC};
`endif

   assign cmd.cmd_ready = (state_q == IDLE);
   assign accept        = cmd.cmd_valid && (state_q == IDLE);
   assign cmd_cruise    = (cmd.cmd_period == '0) ? ONE_P : cmd.cmd_period;

   step_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (accept),
      .tick_o    (tick)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      cur_d    = cur_q;
      pcnt_d   = pcnt_q;
      dir_d    = dir_q;
      rot_d    = rot_q;
      pos_d    = pos_q;
      done_d   = 1'b0;
      step_due = 1'b0;
`ifdef STEP_RAMP_EN
      nacc_d   = nacc_q;
      cruise_d = cruise_q;
`endif
      if (state_q == IDLE) begin
         if (accept) begin
            dir_d  = cmd.cmd_dir;
            rem_d  = cmd.cmd_steps;
            pcnt_d = '0;
`ifdef STEP_RAMP_EN
            nacc_d   = '0;
            cruise_d = cmd_cruise;
            cur_d    = (cmd_cruise > START_P) ? cmd_cruise : START_P;
`else
            cur_d    = cmd_cruise;
`endif
            if (cmd.cmd_steps == '0) begin
               done_d = 1'b1;
            end else begin
`ifdef STEP_RAMP_EN
               state_d = ACCEL;
`else
               state_d = RUN;
`endif
            end
         end
      end else begin
         if (tick) begin
            if (pcnt_q == cur_q - ONE_P) begin
               step_due = 1'b1;
               pcnt_d   = '0;
            end else begin
               pcnt_d   = pcnt_q + ONE_P;
            end
         end

         if (step_due) begin
            rot_d = ~rot_q;
            pos_d = (dir_q == FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_d = rem_q - STEPS_W'(1);
`ifdef STEP_RAMP_EN
            if (state_q == ACCEL) begin
               nacc_d = nacc_q + STEPS_W'(1);
               // cur_q never drops below cruise_q in ACCEL, so the difference cannot wrap
               if ((cur_q - cruise_q) <= DEC_P) begin
                  cur_d   = cruise_q;
                  state_d = RUN;
               end else begin
                  cur_d   = cur_q - DEC_P;
               end
            end else if (state_q == DECEL) begin
               cur_d = ramp_up(cur_q);
            end
`endif
         end

`ifdef STEP_RAMP_EN
         // Entering DECEL reuses the post-step period plus one increment, which mirrors
         // the last ACCEL period so the profile stays symmetric.
         if ((state_q == ACCEL || state_q == RUN) &&
             (stop || (step_due && rem_d <= nacc_d))) begin
            state_d = DECEL;
            cur_d   = ramp_up(cur_d);
            if (stop && nacc_d < rem_d) begin
               rem_d = nacc_d;
            end
         end
         if (rem_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`else
         if (stop || rem_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         cur_q    <= ONE_P;
         pcnt_q   <= '0;
         dir_q    <= REV;
         rot_q    <= 1'b0;
         done_q   <= 1'b0;
         pos_q    <= '0;
`ifdef STEP_RAMP_EN
         nacc_q   <= '0;
         cruise_q <= ONE_P;
`endif
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         cur_q    <= cur_d;
         pcnt_q   <= pcnt_d;
         dir_q    <= dir_d;
         rot_q    <= rot_d;
         done_q   <= done_d;
         pos_q    <= pos_d;
`ifdef STEP_RAMP_EN
         nacc_q   <= nacc_d;
         cruise_q <= cruise_d;
`endif
      end
   end

   assign rotate_pulse  = rot_q;
   assign direction     = dir_q;
   assign busy          = (state_q != IDLE);
   assign module_enable = (state_q != IDLE);
   assign done          = done_q;
   assign position      = pos_q;
endmodule
